// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR/MDR memory-access unit with start/done handshake,
// variable-latency memory ack, access timeout and overrun reporting.
module lc3_mem_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Buss,
   input  logic              ldMAR,
   input  logic              ldMDR,
   input  logic              start,
   input  logic              rw,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ovr_err,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic [CW-1:0]     cnt;
   logic              rw_q, err_q, timeout_hit;
   // An ack arriving on the final allowed cycle still wins over the timeout.
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign err       = done & err_q;
   assign mem_en    = state == ACCESS;
   assign mem_we    = mem_en & rw_q;
   assign mar_out   = mar;
   assign mdr_out   = mdr;
   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         mar     <= '0;
         mdr     <= '0;
         cnt     <= '0;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         if (busy && start) ovr_err <= 1'b1;
         else if (err_clr) ovr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ldMAR) mar <= ADDR_W'(Buss);
               if (ldMDR) mdr <= Buss;
               if (start) begin
                  rw_q  <= rw;
                  cnt   <= '0;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (!rw_q) mdr <= mem_rdata;
                  err_q <= 1'b0;
                  state <= DONE;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else if (TIMEOUT != 0) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: randomized transactions checked against a transaction-level model.
module tb_lc3_mem_ctrl;
   localparam int TO = 8;
   logic        clk = 1'b0, reset = 1'b1;
   logic [15:0] Buss = '0, mem_rdata = '0;
   logic        ldMAR = 0, ldMDR = 0, start = 0, rw = 0, err_clr = 0, mem_ack = 0;
   logic        busy, done, err, ovr_err, mem_en, mem_we;
   logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;
   logic [15:0] m_mar = '0, m_mdr = '0;
   logic        m_ovr = 1'b0;
   int n_tests = 0, n_fail = 0;

   lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .Buss(Buss), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .start(start), .rw(rw), .busy(busy), .done(done), .err(err),
      .ovr_err(ovr_err), .err_clr(err_clr), .mar_out(mar_out), .mdr_out(mdr_out),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit lm, input bit lmd, input logic [15:0] b);
      ldMAR = lm; ldMDR = lmd; Buss = b;
      step();
      ldMAR = 0; ldMDR = 0;
      if (lm) m_mar = b;
      if (lmd) m_mdr = b;
      chk("load_mar", mar_out, m_mar);
      chk("load_mdr", mdr_out, m_mdr);
   endtask

   // lat: ACCESS cycle on which memory acks; values above TO mean no ack at all
   task automatic xact(input bit lm, input bit lmd, input logic [15:0] b, input bit w,
                       input int lat, input logic [15:0] rd, input bit intf,
                       input bit intf_clr, input bit done_clr);
      ldMAR = lm; ldMDR = lmd; Buss = b; start = 1; rw = w;
      if (lm) m_mar = b;
      if (lmd) m_mdr = b;
      step();
      ldMAR = 0; ldMDR = 0; start = 0; rw = 1'($urandom);
      for (int k = 1; k <= TO; k++) begin
         chk("acc_en", mem_en, 1);
         chk("acc_busy", busy, 1);
         chk("acc_done", done, 0);
         chk("acc_addr", mem_addr, m_mar);
         chk("acc_we", mem_we, w);
         chk("acc_ovr", ovr_err, m_ovr);
         if (w) chk("acc_wdata", mem_wdata, m_mdr);
         mem_ack = (k == lat);
         mem_rdata = mem_ack ? rd : 16'($urandom);
         if (intf && k == 2) begin
            start = 1; ldMAR = 1; ldMDR = 1; Buss = 16'hFFFF; err_clr = intf_clr;
            m_ovr = 1'b1;
         end
         step();
         start = 0; ldMAR = 0; ldMDR = 0; err_clr = 0; mem_ack = 0;
         if (k == lat) break;
      end
      if (lat <= TO && !w) m_mdr = rd;
      chk("done_pulse", done, 1);
      chk("done_err", err, lat > TO);
      chk("done_en", mem_en, 0);
      chk("done_mdr", mdr_out, m_mdr);
      chk("done_mar", mar_out, m_mar);
      chk("done_ovr", ovr_err, m_ovr);
      mem_ack = 1; mem_rdata = 16'($urandom); err_clr = done_clr;
      step();
      mem_ack = 0; err_clr = 0;
      if (done_clr) m_ovr = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_en", mem_en, 0);
      chk("idle_mdr", mdr_out, m_mdr);
      chk("idle_ovr", ovr_err, m_ovr);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ovr", ovr_err, 0);
      chk("rst_en", mem_en, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_mar", mar_out, 0);
      chk("rst_mdr", mdr_out, 0);
      reset = 0;
      step();
      xact(1, 0, 16'h3000, 0, 1, 16'hBEEF, 0, 0, 0);
      chk("fast_read", mdr_out, 16'hBEEF);
      load(1, 0, 16'h0040);
      xact(0, 1, 16'h1234, 1, 3, 16'h0000, 0, 0, 0);
      load(0, 1, 16'h5555);
      xact(0, 0, 16'h0000, 0, 99, 16'hAAAA, 0, 0, 0);
      chk("timeout_mdr", mdr_out, 16'h5555);
      xact(0, 0, 16'h0000, 0, 4, 16'h7777, 1, 1, 1);
      chk("ovr_cleared", ovr_err, 0);
      xact(1, 0, 16'h0100, 0, TO, 16'h4242, 0, 0, 0);
      ldMAR = 1; Buss = 16'h1234; start = 1; rw = 0;
      step();
      ldMAR = 0; start = 0;
      step();
      chk("pre_rst_en", mem_en, 1);
      #2 reset = 1;
      #1;
      chk("arst_en", mem_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_mar", mar_out, 0);
      m_mar = '0; m_mdr = '0; m_ovr = 1'b0;
      step();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1'($urandom);
         step();
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      mem_ack = 0;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) load(1'($urandom), 1'($urandom), 16'($urandom));
         xact(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
              $urandom_range(1, TO + 2), 16'($urandom), $urandom_range(0, 3) == 0,
              1'($urandom), 1'($urandom));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
